// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_seq
// Purpose  : Iterative radix-4 Booth multiplier for the ALU MUL path.
//            Signed/unsigned per operation, one digit per clock.
//            Optional macro BOOTH_EARLY_TERM_EN: finish as soon as the
//            remaining multiplier bits can only produce zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int EXTW = WIDTH + 2;
    localparam int QW   = WIDTH + 3;
    localparam int ACCW = 2 * WIDTH + 4;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [CW-1:0] c_cnt_last = CW'(ITER - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [EXTW-1:0]      r_m;
    logic [QW-1:0]        r_q;
    logic [ACCW-1:0]      r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [EXTW-1:0]      w_m_in;
    logic [EXTW-1:0]      w_q_in;
    logic                 w_start_ok;
    logic [ACCW-1:0]      w_m_wide;
    logic [ACCW-1:0]      w_digit;
    logic [ACCW-1:0]      w_term;
    logic [ACCW-1:0]      w_acc_next;
    logic [QW-1:0]        w_q_next;
    logic                 w_last;

    // Two extra bits give the unsigned top digit room to stay non-negative.
    assign w_m_in = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                : {2'b00, multiplicand};
    assign w_q_in = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                : {2'b00, multiplier};

    assign w_start_ok = start && (r_state != S_RUN);
    assign w_m_wide   = {{(ACCW - EXTW){r_m[EXTW-1]}}, r_m};

    always_comb begin
        w_digit = '0;
        case (r_q[2:0])
            3'b001, 3'b010: w_digit = w_m_wide;
            3'b011:         w_digit = w_m_wide << 1;
            3'b100:         w_digit = -(w_m_wide << 1);
            3'b101, 3'b110: w_digit = -w_m_wide;
            default:        w_digit = '0;
        endcase
    end

    assign w_term     = w_digit << {r_cnt, 1'b0};
    assign w_acc_next = r_acc + w_term;
    assign w_q_next   = {{2{r_q[QW-1]}}, r_q[QW-1:2]};

`ifdef BOOTH_EARLY_TERM_EN
    // Uniform remaining bits decode to zero digits from here on.
    assign w_last = (r_cnt == c_cnt_last) || (w_q_next == '0) || (w_q_next == '1);
`else
    assign w_last = (r_cnt == c_cnt_last);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_start_ok) begin
            r_m   <= w_m_in;
            r_q   <= {w_q_in, 1'b0};
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + c_cnt_one;
            if (w_last) begin
                r_product <= w_acc_next[2*WIDTH-1:0];
            end
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mul_seq
// Purpose  : Self-checking bench for booth_mul_seq (WIDTH=32 and WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mul_seq;

    localparam int W  = 32;
    localparam int IT = W / 2 + 1;

`ifdef BOOTH_EARLY_TERM_EN
    localparam int LAT_FULL = -1;
    localparam int LAT_5X3  = 3;
    localparam int LAT_5XM1 = 2;
    localparam int LAT_W8   = 5;
`else
    localparam int LAT_FULL = IT + 1;
    localparam int LAT_5X3  = IT + 1;
    localparam int LAT_5XM1 = IT + 1;
    localparam int LAT_W8   = 6;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             signed_mode;
    logic [W-1:0]     mc;
    logic [W-1:0]     mq;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    logic             start8;
    logic             sm8;
    logic [7:0]       mc8;
    logic [7:0]       mq8;
    logic             busy8;
    logic             done8;
    logic [15:0]      product8;

    int checks = 0;
    int errors = 0;

    booth_mul_seq #(.WIDTH(W)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (mc),
        .multiplier   (mq),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    booth_mul_seq #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .reset        (reset),
        .start        (start8),
        .signed_mode  (sm8),
        .multiplicand (mc8),
        .multiplier   (mq8),
        .busy         (busy8),
        .done         (done8),
        .product      (product8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic sm, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        if (sm) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

`ifdef BOOTH_EARLY_TERM_EN
    // Digits consumed before the still-unread multiplier bits are uniform.
    function automatic int exp_iters(input logic sm, input logic [W-1:0] q);
        logic [W+2:0] r;
        r = {(sm ? {2{q[W-1]}} : 2'b00), q, 1'b0};
        for (int k = 1; k <= IT; k++) begin
            r = {{2{r[W+2]}}, r[W+2:2]};
            if (r == '0 || r == '1) return k;
        end
        return IT;
    endfunction
`endif

    // Reference timeline: cycles of busy remaining, done pulse, held product.
    int             m_left = 0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_pend = '0;
    bit             m_live = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_prod = '0;
            m_live = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_left == 0) m_prod = m_pend;
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pend = ref_mul(signed_mode, mc, mq);
`ifdef BOOTH_EARLY_TERM_EN
                m_left = exp_iters(signed_mode, mq);
`else
                m_left = IT;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model busy", 64'(busy), 64'(m_left > 0));
            check("model done", 64'(done), 64'(m_done));
            check("model product", product, m_prod);
        end
    end

    task automatic launch(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        start       = 1'b1;
        signed_mode = sm;
        mc          = a;
        mq          = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i + 1;
                break;
            end
            if (busy) busy_n++;
        end
        if (lat < 0) check("done timeout", 64'(0), 64'(1));
    endtask

    task automatic run(input string name, input logic sm, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] exp, input int exp_lat);
        int lat;
        int bn;
        launch(sm, a, b);
        wait_done(lat, bn);
        check(name, product, exp);
        if (exp_lat > 0) begin
            check({name, " latency"}, 64'(lat), 64'(exp_lat));
            check({name, " busy cycles"}, 64'(bn), 64'(exp_lat - 1));
        end
    endtask

    initial begin
        int lat;
        int bn;
        int seen;
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        mc          = '0;
        mq          = '0;
        start8      = 1'b0;
        sm8         = 1'b0;
        mc8         = '0;
        mq8         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset product", product, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run("s 7*-3", 1'b1, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, LAT_FULL);
        run("u max*max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, LAT_FULL);
        run("s -1*-1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1, -1);
        run("s min*min", 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, -1);
        run("s min*1", 1'b1, 32'h80000000, 32'h1, 64'hFFFFFFFF80000000, -1);
        run("u 2^31*2", 1'b0, 32'h80000000, 32'h2, 64'h100000000, -1);
        run("u max*0", 1'b0, 32'hFFFFFFFF, 32'h0, 64'h0, -1);
        run("s 5*3", 1'b1, 32'd5, 32'd3, 64'd15, LAT_5X3);
        run("s 5*-1", 1'b1, 32'd5, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFB, LAT_5XM1);

        // start in the first RUN cycle with new operands must be ignored
        launch(1'b0, 32'd6, 32'd7);
        start = 1'b1;
        mc    = 32'd9;
        mq    = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bn);
        check("mid-run start ignored", product, 64'd42);
        repeat (3) @(negedge clk);
        check("no restart after ignore", 64'(busy), 64'(0));

        // back-to-back: start held through the DONE cycle
        launch(1'b0, 32'd5, 32'd5);
        wait_done(lat, bn);
        check("b2b first", product, 64'd25);
        start = 1'b1;
        mc    = 32'd3;
        mq    = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b rerun busy", 64'(busy), 64'(1));
        check("b2b product held", product, 64'd25);
        wait_done(lat, bn);
        check("b2b second", product, 64'd9);

        // reset during an operation aborts it without a done pulse
        launch(1'b1, 32'h12345678, 32'h07654321);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'(0));
        check("abort product", product, 64'h0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort no done", 64'(seen), 64'(0));
        run("s 2*-2", 1'b1, 32'd2, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFC, -1);

        // WIDTH=8 signed extreme
        @(posedge clk);
        #1;
        start8 = 1'b1;
        sm8    = 1'b1;
        mc8    = 8'h80;
        mq8    = 8'h80;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat    = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i + 1;
                break;
            end
        end
        check("w8 min*min", 64'(product8), 64'd16384);
        check("w8 latency", 64'(lat), 64'(LAT_W8));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Parametrised, multi-cycle radix-4 Booth multiplier for the ALU MUL path.
- Generalises the combinational Booth multiplier in three ways:
  - WIDTH-bit operands.
  - Signed or unsigned mode, selected per operation.
  - Iterative datapath: one radix-4 digit per clock, with a start/busy/done handshake.
- The control unit stalls on busy and captures product when done pulses.

Parameters:
- WIDTH, default 32: operand width. Must be even and >= 4. Product is 2*WIDTH bits.
- ITER, default WIDTH/2+1: iteration count, derived and not overridden. Operands are extended internally to WIDTH+2 bits.

Ports:
- clk  input  1: single clock, rising edge.
- reset  input  1: synchronous, active-high reset.
- start  input  1: request a new multiply. Sampled only in IDLE or DONE.
- signed_mode  input  1: 1 means two's-complement operands, 0 means unsigned. Sampled with start.
- multiplicand  input  WIDTH: operand M. Sampled with start.
- multiplier  input  WIDTH: operand Q. Sampled with start.
- busy  output  1: high while in RUN.
- done  output  1: one-cycle pulse when product becomes valid.
- product  output  2*WIDTH: result. Held stable until the next accepted start.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, product=0, and all internal registers cleared.
  - Reset in any state, including mid-RUN, aborts the operation.
  - No done pulse is produced for an aborted operation.
- States:
  - IDLE: waiting. start=1 at an edge goes to RUN.
  - RUN: one iteration per cycle. After the ITER-th iteration, go to DONE.
  - DONE: done=1 for exactly one cycle.
    - If start=1 in DONE, go directly to RUN (back-to-back operations).
    - Otherwise go to IDLE.
- Start capture:
  - Extend M and Q to WIDTH+2 bits: sign-extend if signed_mode=1, zero-extend if 0.
  - Load the accumulator with 0, the Q shift register with {Qext, 1'b0} (guard bit), and the iteration counter with 0.
  - start while busy=1 is ignored and the operands are not re-sampled.
- Iteration k:
  - Take the triple = low 3 bits of the Q shift register.
  - Select the digit: 000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M.
  - acc += sign-extended digit << 2k, computed in 2*WIDTH+4 bits.
  - Shift the Q register right arithmetically by 2.
- Result: product = acc[2*WIDTH-1:0], registered on the transition into DONE.
- Latency (without the optional feature): start sampled at edge t gives busy=1 from t+1 through t+ITER, and done=1 in the cycle after edge t+ITER+1. For WIDTH=32 this is done in the 18th cycle after start.
- Arithmetic:
  - The unsigned extra digit makes the full 2^WIDTH range exact.
  - The signed extra digit is always 0.
  - No overflow is possible; the truncation to 2*WIDTH bits is exact.
- Simultaneous events:
  - reset dominates start.
  - In DONE with start=1, done is still asserted in that cycle, and product updates only at the next DONE.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined: after each iteration, if the remaining Q shift register bits (including the guard bit) are all 0 or all 1, go directly to DONE. All remaining digits are zero, so the result is unchanged and latency becomes variable (minimum 1 iteration).
- Undefined: fixed latency of ITER iterations with no early-termination logic.

Test Plan:
- Signed short operation, WIDTH=32: signed_mode=1, M=7, Q=-3 (0xFFFFFFFD) -> product=0xFFFFFFFFFFFFFFEB, busy high for 17 cycles, single done pulse in the 18th cycle.
- Unsigned extreme, WIDTH=32: signed_mode=0, M=Q=0xFFFFFFFF -> product=0xFFFFFFFE00000001. Repeating with signed_mode=1 gives product=1.
- Signed extreme, WIDTH=32: M=Q=0x80000000, signed_mode=1 -> product=0x4000000000000000. M=0x80000000, Q=1 -> product=0xFFFFFFFF80000000.
- Handshake, WIDTH=32:
  - start pulsed with new operands in mid-RUN -> ignored; the first result (e.g. 6*7=42) is still returned.
  - start held in the DONE cycle with 3*3 -> RUN re-entered immediately and product=9 after the next done.
- Reset mid-operation, WIDTH=32: reset asserted at iteration 5 -> busy=0, product=0, and no done pulse. A subsequent 2*-2 -> product=-4.
- BOOTH_EARLY_TERM_EN defined, M=5, Q=3 -> 2 iterations, done in the 3rd cycle after start, product=15. Q=-1 -> 1 iteration, product=-5. Also check WIDTH=8: M=-128, Q=-128 -> product=16384, with full iterations when the macro is undefined.
